// File: rtl/imem_loader.sv
// Boot loader: framed byte stream in, 32-bit instruction-memory writes out, core reset release.
// Latency: write strobe registered one cycle after the 4th byte of a word; done/release one cycle after a good checksum.
// Backpressure: rx_ready_o is high in every state except DONE (and low while rst_i is asserted).
module imem_loader #(
  parameter int          MEM_SIZE_INST = 1024,
  parameter logic [7:0]  START_BYTE    = 8'hA5
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [7:0]                       rx_data_i,
  input  logic                             rx_valid_i,
  output logic                             rx_ready_o,
  output logic                             we_o,
  output logic [$clog2(MEM_SIZE_INST)-1:0] waddr_o,
  output logic [31:0]                      wdata_o,
  output logic                             core_rst_n_o,
  output logic                             done_o,
  output logic                             error_o
);

  localparam int          AW    = $clog2(MEM_SIZE_INST);
  localparam logic [16:0] MEM_N = 17'(MEM_SIZE_INST);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN0,
    S_LEN1,
    S_DATA,
    S_CSUM,
    S_DONE,
    S_ERR
  } state_t;

  state_t          state_q, state_d;
  logic [15:0]     len_q, len_d;       // word count N of the current frame
  logic [15:0]     addr_q, addr_d;     // next word address to write
  logic [1:0]      cnt_q, cnt_d;       // byte position within the current word
  logic [31:0]     word_q, word_d;     // little-endian word assembler
  logic [7:0]      xor_q, xor_d;       // running XOR of data bytes
  logic            we_q, we_d;
  logic [AW-1:0]   waddr_q, waddr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic            done_q, done_d;
  logic            err_q, err_d;

  logic            accept;
  logic [16:0]     n_new;

  assign rx_ready_o   = ~rst_i && (state_q != S_DONE);
  assign accept       = rx_valid_i && rx_ready_o;
  assign n_new        = {1'b0, rx_data_i, len_q[7:0]};

  assign we_o         = we_q;
  assign waddr_o      = waddr_q;
  assign wdata_o      = wdata_q;
  assign done_o       = done_q;
  assign core_rst_n_o = done_q;
  assign error_o      = err_q;

  // Next-state and output decode; nothing moves unless a byte is accepted.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    xor_d   = xor_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    done_d  = done_q;
    err_d   = err_q;
    if (accept) begin
      case (state_q)
        S_IDLE: begin
          if (rx_data_i == START_BYTE) state_d = S_LEN0;
        end
        S_LEN0: begin
          len_d[7:0] = rx_data_i;
          state_d    = S_LEN1;
        end
        S_LEN1: begin
          len_d[15:8] = rx_data_i;
          addr_d      = 16'd0;
          cnt_d       = 2'd0;
          xor_d       = 8'h00;
          if (n_new > MEM_N) begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end else if (n_new == 17'd0) begin
            state_d = S_CSUM;
          end else begin
            state_d = S_DATA;
          end
        end
        S_DATA: begin
          word_d = {rx_data_i, word_q[31:8]};
          xor_d  = xor_q ^ rx_data_i;
          cnt_d  = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            we_d    = 1'b1;
            waddr_d = addr_q[AW-1:0];
            wdata_d = {rx_data_i, word_q[31:8]};
            addr_d  = addr_q + 16'd1;
            if (addr_q == len_q - 16'd1) state_d = S_CSUM;
          end
        end
        S_CSUM: begin
          if (rx_data_i == xor_q) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end
        end
        S_ERR: begin
          if (rx_data_i == START_BYTE) begin
            state_d = S_LEN0;
            err_d   = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // State and registered outputs; reset drops any pending write and holds the core in reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      addr_q  <= '0;
      cnt_q   <= '0;
      word_q  <= '0;
      xor_q   <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      xor_q   <= xor_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

endmodule
